// File: rtl/step_pulse_gen_if.sv
// Button-to-step-counter link: raw button level and enable in, clean step
// pulse plus debounced status out.
interface step_pulse_gen_if;
  logic btn_in;
  logic en;
  logic x;
  logic pressed;
  logic repeat_active;

  // Drives the button and enable; observes the step pulse and status.
  modport master (
    output btn_in,
    output en,
    input  x,
    input  pressed,
    input  repeat_active
  );

  // The pulse generator itself.
  modport slave (
    input  btn_in,
    input  en,
    output x,
    output pressed,
    output repeat_active
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Step pulse generator: synchronizes and debounces a raw push-button and
// emits one-cycle step pulses (press, then auto-repeat while held) for the
// downstream step counter FSM. One shared counter times debounce, repeat
// delay and repeat rate; compares are equality-only and the counter never
// passes the active terminal value.
module step_pulse_gen #(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  step_pulse_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             s1;
  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             x_r;
  logic             pressed_r;
  logic             repeat_r;

  assign bus.x             = x_r;
  assign bus.pressed       = pressed_r;
  assign bus.repeat_active = repeat_r;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= bus.btn_in;
      btn_s <= s1;
    end
  end

  // Debounce / auto-repeat FSM with registered outputs; x defaults low so a
  // pulse lasts exactly one cycle and en only gates the pulse itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      x_r       <= 1'b0;
      pressed_r <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      x_r <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            pressed_r <= 1'b1;
            x_r       <= bus.en;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (cnt == DELAY_LAST) begin
            state    <= REPEAT;
            cnt      <= '0;
            repeat_r <= 1'b1;
            x_r      <= bus.en;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state    <= DEB_RELEASE;
            cnt      <= '0;
            repeat_r <= 1'b0;
          end else if (cnt == RATE_LAST) begin
            cnt <= '0;
            x_r <= bus.en;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DEB_RELEASE: begin
          // A brief high here is a release glitch: back to HELD, timer restarts.
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            pressed_r <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          repeat_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
